// File: rtl/mem_stream_reader.sv
// Stream read engine: issues buffer-RAM reads for a (addr, len) command and emits the words as AXI4-Stream.
// Optional stall counter port and logic enabled with `define MEM_READER_STALL_CNT_EN.
module mem_stream_reader #(
  parameter int DEPTH     = 8,
  parameter int DATA_SIZE = 32,
  parameter int LEN_W     = 16,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        addrb,
  input  logic [DATA_SIZE-1:0] doutb,
  output logic [DATA_SIZE-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast
`ifdef MEM_READER_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state, state_nx;
  logic [LEN_W-1:0]     len_r, issued, beat_cnt;
  logic                 inflight;
  logic [1:0]           fifo_cnt;
  logic [DATA_SIZE-1:0] q0, q1;
  logic                 accept, issue, pop, push, last_pop, done_nx;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign m_tvalid  = (fifo_cnt != 2'd0);
  assign m_tdata   = q0;
  assign m_tlast   = m_tvalid && (beat_cnt == len_r - LEN_W'(1));
  assign pop       = m_tvalid && m_tready;
  assign push      = inflight;
  assign last_pop  = pop && m_tlast;

  // Only issue when the word returning next cycle is guaranteed a free FIFO slot.
  assign issue = (state == RUN) && (issued != len_r) &&
                 (({1'b0, fifo_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_len == '0) done_nx  = 1'b1;
          else               state_nx = RUN;
        end
      end
      RUN: begin
        if (issue && (issued == len_r - LEN_W'(1))) state_nx = DRAIN;
      end
      DRAIN: begin
        if (last_pop) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      inflight <= 1'b0;
      len_r    <= '0;
      issued   <= '0;
      beat_cnt <= '0;
      addrb    <= '0;
    end else begin
      state    <= state_nx;
      done     <= done_nx;
      inflight <= issue;
      if (accept) begin
        len_r    <= cmd_len;
        addrb    <= cmd_addr;
        issued   <= '0;
        beat_cnt <= '0;
      end else begin
        if (issue) begin
          addrb  <= (addrb == AW'(DEPTH - 1)) ? '0 : addrb + AW'(1);
          issued <= issued + LEN_W'(1);
        end
        if (pop) beat_cnt <= beat_cnt + LEN_W'(1);
      end
    end
  end

  // Two-entry FIFO kept head-aligned so m_tdata is always q0.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_cnt <= 2'd0;
      q0       <= '0;
      q1       <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) q0 <= doutb;
          else                  q1 <= doutb;
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          q0       <= q1;
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) q0 <= doutb;
          else begin
            q0 <= q1;
            q1 <= doutb;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_READER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                          stall_cnt <= '0;
    else if (accept)                                  stall_cnt <= '0;
    else if (m_tvalid && !m_tready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
